// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage -- instruction decode (ID) stage of a 5-stage MIPS-like core.
//
// Decodes the IF/ID entry, reads the register file (with write-through of the
// same-cycle writeback), detects load-use hazards, resolves BEQ/BNE/J early
// using forwarded compare operands, and runs a halt FSM (RUN/DRAIN/HALTED).
// The ID/EX payload and controls are registered (one cycle latency).
//
// Ports:
//   i_clk, i_reset (sync, active-low)
//   i_valid, i_instruccion, i_pc_4            IF/ID entry
//   i_wb_we, i_wb_addr, i_wb_data             register-file write port
//   i_ex_mem_read, i_ex_rt                    load in EX (hazard detection)
//   i_ex_we/dst/data, i_mem_we/dst/data       forwarding for branch compare
//   o_stall, o_flush, o_jump_addr             combinational IF control
//   o_valid, o_rs_data, o_rt_data, o_imm,
//   o_rs, o_dst, o_memtoReg, o_regWrite,
//   o_memWrite, o_memRead, o_ALUSrc, o_ALUOp  registered ID/EX payload
//   o_halt                                    pipeline halted
//
// Optional feature (macro DECODE_DEBUG_PORT_EN): adds i_dbg_addr/o_dbg_data,
// a combinational register-file read without writeback bypass.
// ---------------------------------------------------------------------------
module decode_stage #(
  parameter int N_BITS       = 32,
  parameter int N_REG_BITS   = 5,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic [N_BITS-1:0]     i_instruccion,
  input  logic [N_BITS-1:0]     i_pc_4,
  input  logic                  i_wb_we,
  input  logic [N_REG_BITS-1:0] i_wb_addr,
  input  logic [N_BITS-1:0]     i_wb_data,
  input  logic                  i_ex_mem_read,
  input  logic [N_REG_BITS-1:0] i_ex_rt,
  input  logic                  i_ex_we,
  input  logic [N_REG_BITS-1:0] i_ex_dst,
  input  logic [N_BITS-1:0]     i_ex_data,
  input  logic                  i_mem_we,
  input  logic [N_REG_BITS-1:0] i_mem_dst,
  input  logic [N_BITS-1:0]     i_mem_data,
  output logic                  o_stall,
  output logic                  o_flush,
  output logic [N_BITS-1:0]     o_jump_addr,
  output logic                  o_valid,
  output logic [N_BITS-1:0]     o_rs_data,
  output logic [N_BITS-1:0]     o_rt_data,
  output logic [N_BITS-1:0]     o_imm,
  output logic [N_REG_BITS-1:0] o_rs,
  output logic [N_REG_BITS-1:0] o_dst,
  output logic                  o_memtoReg,
  output logic                  o_regWrite,
  output logic                  o_memWrite,
  output logic                  o_memRead,
  output logic                  o_ALUSrc,
  output logic [1:0]            o_ALUOp,
  output logic                  o_halt
`ifdef DECODE_DEBUG_PORT_EN
  ,
  input  logic [N_REG_BITS-1:0] i_dbg_addr,
  output logic [N_BITS-1:0]     o_dbg_data
`endif
);

  localparam int DEPTH = 1 << N_REG_BITS;
  localparam int CNT_W = 4;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [N_BITS-1:0]       rf_q [DEPTH];

  logic [5:0]              op;
  logic [N_REG_BITS-1:0]   rs, rt, rd;
  logic [N_BITS-1:0]       imm, rf_rs, rf_rt, fwd_rs, fwd_rt;
  logic [N_BITS-1:0]       br_target, j_target;
  logic                    uses_rt, load_use, running, accept, taken;
  logic                    c_memtoReg, c_regWrite, c_memWrite, c_memRead, c_ALUSrc;
  logic [1:0]              c_ALUOp;

  logic                    valid_q, memtoReg_q, regWrite_q, memWrite_q, memRead_q, ALUSrc_q;
  logic [1:0]              ALUOp_q;
  logic [N_BITS-1:0]       rs_data_q, rt_data_q, imm_q;
  logic [N_REG_BITS-1:0]   rs_q, dst_q;

  assign op  = i_instruccion[31:26];
  assign rs  = N_REG_BITS'(i_instruccion[25:21]);
  assign rt  = N_REG_BITS'(i_instruccion[20:16]);
  assign rd  = N_REG_BITS'(i_instruccion[15:11]);
  assign imm = {{(N_BITS-16){i_instruccion[15]}}, i_instruccion[15:0]};

  // Register-file read with write-through of this cycle's writeback.
  assign rf_rs = (rs == '0) ? '0 :
                 (i_wb_we && (i_wb_addr == rs)) ? i_wb_data : rf_q[rs];
  assign rf_rt = (rt == '0) ? '0 :
                 (i_wb_we && (i_wb_addr == rt)) ? i_wb_data : rf_q[rt];

  // Branch operands: youngest producer (EX) wins over MEM, then register file.
  assign fwd_rs = (i_ex_we  && (i_ex_dst  != '0) && (i_ex_dst  == rs)) ? i_ex_data  :
                  (i_mem_we && (i_mem_dst != '0) && (i_mem_dst == rs)) ? i_mem_data : rf_rs;
  assign fwd_rt = (i_ex_we  && (i_ex_dst  != '0) && (i_ex_dst  == rt)) ? i_ex_data  :
                  (i_mem_we && (i_mem_dst != '0) && (i_mem_dst == rt)) ? i_mem_data : rf_rt;

  assign br_target = i_pc_4 + (imm << 2);
  assign j_target  = {i_pc_4[N_BITS-1:28], i_instruccion[25:0], 2'b00};

  // rt is a source operand only for these formats; for LW/ADDI it is the destination.
  assign uses_rt  = (op == OP_R) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
  assign load_use = i_valid && i_ex_mem_read && (i_ex_rt != '0) &&
                    ((i_ex_rt == rs) || (uses_rt && (i_ex_rt == rt)));
  assign running  = (state_q == RUN);
  assign accept   = running && i_valid && !load_use;
  assign taken    = ((op == OP_BEQ) && (fwd_rs == fwd_rt)) ||
                    ((op == OP_BNE) && (fwd_rs != fwd_rt));

  // Stall dominates: a stalled branch never flushes because accept is low.
  assign o_stall     = !running || load_use;
  assign o_flush     = accept && (taken || (op == OP_J));
  assign o_jump_addr = (op == OP_J) ? j_target : br_target;
  assign o_halt      = (state_q == HALTED);

  always_comb begin
    c_memtoReg = 1'b0;
    c_regWrite = 1'b0;
    c_memWrite = 1'b0;
    c_memRead  = 1'b0;
    c_ALUSrc   = 1'b0;
    c_ALUOp    = 2'b00;
    unique case (op)
      OP_R:    begin c_regWrite = 1'b1; c_ALUOp = 2'b10; end
      OP_LW:   begin c_memtoReg = 1'b1; c_regWrite = 1'b1; c_memRead = 1'b1; c_ALUSrc = 1'b1; end
      OP_SW:   begin c_memWrite = 1'b1; c_ALUSrc = 1'b1; end
      OP_ADDI: begin c_regWrite = 1'b1; c_ALUSrc = 1'b1; end
      OP_BEQ,
      OP_BNE:  c_ALUOp = 2'b01;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (accept && (op == OP_HALT)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
          state_d = HALTED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HALTED:  ;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Register 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
    end else if (i_wb_we && (i_wb_addr != '0)) begin
      rf_q[i_wb_addr] <= i_wb_data;
    end
  end

  // ID/EX register: non-accepted cycles become bubbles (valid and controls low).
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      valid_q    <= 1'b0;
      memtoReg_q <= 1'b0;
      regWrite_q <= 1'b0;
      memWrite_q <= 1'b0;
      memRead_q  <= 1'b0;
      ALUSrc_q   <= 1'b0;
      ALUOp_q    <= 2'b00;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      rs_q       <= '0;
      dst_q      <= '0;
    end else begin
      valid_q    <= accept;
      memtoReg_q <= accept && c_memtoReg;
      regWrite_q <= accept && c_regWrite;
      memWrite_q <= accept && c_memWrite;
      memRead_q  <= accept && c_memRead;
      ALUSrc_q   <= accept && c_ALUSrc;
      ALUOp_q    <= accept ? c_ALUOp : 2'b00;
      if (accept) begin
        rs_data_q <= rf_rs;
        rt_data_q <= rf_rt;
        imm_q     <= imm;
        rs_q      <= rs;
        dst_q     <= (op == OP_R) ? rd : rt;
      end
    end
  end

  assign o_valid    = valid_q;
  assign o_memtoReg = memtoReg_q;
  assign o_regWrite = regWrite_q;
  assign o_memWrite = memWrite_q;
  assign o_memRead  = memRead_q;
  assign o_ALUSrc   = ALUSrc_q;
  assign o_ALUOp    = ALUOp_q;
  assign o_rs_data  = rs_data_q;
  assign o_rt_data  = rt_data_q;
  assign o_imm      = imm_q;
  assign o_rs       = rs_q;
  assign o_dst      = dst_q;

`ifdef DECODE_DEBUG_PORT_EN
  assign o_dbg_data = (i_dbg_addr == '0) ? '0 : rf_q[i_dbg_addr];
`else
  // Debug read port not built.
`endif

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter N_BITS, default 32, data/instruction width.
REQ-002 Parameter N_REG_BITS, default 5, register address width; register file depth 2^N_REG_BITS.
REQ-003 Parameter DRAIN_CYCLES, default 3, cycles to wait after HALT before halted; range 1..15.
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 i_clk  in  1  clock, all state on rising edge.
REQ-006 i_reset  in  1  synchronous active-low reset.
REQ-007 i_valid  in  1  i_instruccion/i_pc_4 hold a valid IF/ID entry.
REQ-008 i_instruccion  in  N_BITS  fetched instruction; i_pc_4  in  N_BITS  PC+4 of it.
REQ-009 i_wb_we  in  1; i_wb_addr  in  N_REG_BITS; i_wb_data  in  N_BITS  writeback port.
REQ-010 i_ex_mem_read  in  1; i_ex_rt  in  N_REG_BITS  load in EX and its destination.
REQ-011 i_ex_we, i_mem_we  in  1; i_ex_dst, i_mem_dst  in  N_REG_BITS; i_ex_data, i_mem_data  in  N_BITS  forwarding sources for branch compare.
REQ-012 o_stall  out  1  IF/ID must hold; o_flush  out  1  squash IF/ID; o_jump_addr  out  N_BITS  redirect target.
REQ-013 o_valid  out  1; o_rs_data, o_rt_data, o_imm  out  N_BITS; o_rs, o_dst  out  N_REG_BITS  registered ID/EX payload.
REQ-014 o_memtoReg, o_regWrite, o_memWrite, o_memRead, o_ALUSrc  out  1; o_ALUOp  out  2  registered controls.
REQ-015 o_halt  out  1  pipeline halted.

Function
REQ-016 Decoded opcodes: R-type 000000, LW 100011, SW 101011, ADDI 001000, BEQ 000100, BNE 000101, J 000010, HALT 111111; all others decode as NOP (all controls 0).
REQ-017 Register file: write on rising edge when i_wb_we and i_wb_addr!=0; register 0 reads 0 always.
REQ-018 Reads bypass same-cycle write: read address equal to nonzero i_wb_addr with i_wb_we returns i_wb_data.
REQ-019 o_dst = rt for LW/ADDI, rd for R-type; o_imm = sign-extended instr[15:0].
REQ-020 ID/EX payload latency exactly one cycle from accepted instruction.
REQ-021 Load-use stall: i_valid, i_ex_mem_read, i_ex_rt!=0 and i_ex_rt equal rs, or rt for R-type/SW/BEQ/BNE -> o_stall=1 combinationally; next cycle o_valid=0 and all controls 0 (bubble).
REQ-022 Branch compare operands forwarded, priority EX (i_ex_we, i_ex_dst match, nonzero) over MEM over register file.
REQ-023 Taken BEQ/BNE: o_flush=1, o_jump_addr = i_pc_4 + (o_imm<<2), same cycle; J: o_jump_addr = {i_pc_4[N_BITS-1:28], instr[25:0], 2'b00}.
REQ-024 Stall has priority over flush; no flush while o_stall=1.
REQ-025 Halt FSM states RUN, DRAIN, HALTED; RUN->DRAIN on valid unstalled HALT; DRAIN counts DRAIN_CYCLES cycles issuing bubbles, then HALTED; HALTED exits only by reset.
REQ-026 In DRAIN and HALTED: o_stall=1, o_flush=0, o_valid=0, register-file writes still accepted.
REQ-027 o_halt=1 only in HALTED.
REQ-028 i_valid=0 produces a bubble next cycle and no stall/flush.

Reset
REQ-029 i_reset=0 on a rising edge: FSM to RUN, drain counter 0, all registered outputs 0, all registers 0, overriding any stall, drain or halt in progress.

Configuration
REQ-030 Macro DECODE_DEBUG_PORT_EN defined: extra ports i_dbg_addr in N_REG_BITS and o_dbg_data out N_BITS, combinational read of register file without bypass, for the debug unit.
REQ-031 Macro undefined: ports absent, behaviour otherwise identical.

Verification
REQ-032 Reset, write r5=0x1234 via WB, ADD r3,r5,r0 same cycle -> next cycle o_rs_data=0x1234, o_dst=3, o_regWrite=1.
REQ-033 i_ex_mem_read=1, i_ex_rt=4, decode ADD r2,r4,r1 -> o_stall=1, next o_valid=0; retry without load -> o_valid=1.
REQ-034 BEQ r1,r2,+3 at i_pc_4=0x40, i_ex_dst=1 data=7, r2=7 -> o_flush=1, o_jump_addr=0x4C.
REQ-035 HALT with DRAIN_CYCLES=3 -> o_stall high, o_halt rises exactly after 3 drain cycles, stays high; reset low -> o_halt=0, RUN.
REQ-036 WB write to r0 with 0xFFFF -> subsequent read of r0 returns 0.
